// File: rtl/pipe_stage_buffer.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// in_ready is registered, so back-pressure never forms a combinational path across the stage.
module pipe_stage_buffer #(
  parameter int unsigned CTRL_W = 3,
  parameter int unsigned DATA_W = 132,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state;
  logic               main_valid;
  logic               skid_valid;
  logic [CTRL_W-1:0]  main_ctrl;
  logic [CTRL_W-1:0]  skid_ctrl;
  logic [DATA_W-1:0]  main_data;
  logic [DATA_W-1:0]  skid_data;
  logic [CNT_W-1:0]   stall_q;
  logic               accept_c;
  logic               release_c;

  // Handshake outputs: registered valids gated only by freeze and reset
  assign in_ready    = rst & ~skid_valid & ~freeze;
  assign out_valid   = main_valid & ~freeze;
  assign out_ctrl    = main_ctrl;
  assign out_data    = main_data;
  assign occupancy   = 2'(state);
  assign stall_count = stall_q;

  assign accept_c  = in_valid & in_ready;
  assign release_c = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= EMPTY;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
      main_data  <= '0;
      skid_data  <= '0;
      stall_q    <= '0;
    end else if (flush) begin
      // Flush kills every held beat and drops any beat offered this cycle
      state      <= EMPTY;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
    end else if (!freeze) begin
      if (main_valid && !out_ready && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      unique case (state)
        EMPTY: begin
          if (accept_c) begin
            state      <= ONE;
            main_valid <= 1'b1;
            main_ctrl  <= in_ctrl;
            main_data  <= in_data;
          end
        end
        ONE: begin
          if (accept_c && release_c) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (accept_c) begin
            state      <= FULL;
            skid_valid <= 1'b1;
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
          end else if (release_c) begin
            state      <= EMPTY;
            main_valid <= 1'b0;
            main_ctrl  <= '0;
          end
        end
        FULL: begin
          // Skid beat moves up; skid control zeroed as it becomes a bubble
          if (release_c) begin
            state      <= ONE;
            skid_valid <= 1'b0;
            main_ctrl  <= skid_ctrl;
            main_data  <= skid_data;
            skid_ctrl  <= '0;
          end
        end
        default: begin
          state      <= EMPTY;
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
          main_ctrl  <= '0;
          skid_ctrl  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed self-checking bench for pipe_stage_buffer (narrow data, 2-bit stall counter).
module tb_pipe_stage_buffer;

  localparam int unsigned CTRL_W = 3;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              freeze;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_count;

  int tests = 0;
  int fails = 0;

  pipe_stage_buffer #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = d;
  endtask

  logic [CNT_W-1:0] sat_exp [6];

  initial begin
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    rst = 1'b0; freeze = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_ctrl = '0; in_data = '0; out_ready = 1'b0;

    // Reset state
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_stall", 64'(stall_count), 64'd0);
    @(negedge clk); rst = 1'b1;
    tick();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_occ", 64'(occupancy), 64'd0);
    chk("post_rst_ctrl", 64'(out_ctrl), 64'd0);

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      offer(3'b101, DATA_W'(i));
      tick();
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_data", 64'(out_data), 64'(i));
      chk("stream_ctrl", 64'(out_ctrl), 64'h5);
      chk("stream_occ", 64'(occupancy), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain_valid", 64'(out_valid), 64'd0);
    chk("stream_drain_ctrl", 64'(out_ctrl), 64'd0);
    chk("stream_drain_occ", 64'(occupancy), 64'd0);
    chk("stream_stall", 64'(stall_count), 64'd0);

    // Back-pressure: A then B fill main and skid
    out_ready = 1'b0;
    offer(3'b011, 16'h00AA);
    tick();
    chk("bp_a_occ", 64'(occupancy), 64'd1);
    chk("bp_a_in_ready", 64'(in_ready), 64'd1);
    chk("bp_a_stall", 64'(stall_count), 64'd0);
    offer(3'b110, 16'h00BB);
    tick();
    in_valid = 1'b0;
    chk("bp_full_occ", 64'(occupancy), 64'd2);
    chk("bp_full_in_ready", 64'(in_ready), 64'd0);
    chk("bp_full_data", 64'(out_data), 64'h00AA);
    chk("bp_full_stall", 64'(stall_count), 64'd1);

    // Freeze while FULL for 3 cycles
    freeze = 1'b1;
    #1;
    chk("frz_in_ready", 64'(in_ready), 64'd0);
    chk("frz_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_occ", 64'(occupancy), 64'd2);
      chk("frz_data", 64'(out_data), 64'h00AA);
      chk("frz_ctrl", 64'(out_ctrl), 64'h3);
      chk("frz_stall", 64'(stall_count), 64'd1);
      chk("frz_out_valid_hold", 64'(out_valid), 64'd0);
    end
    freeze = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("unfrz_out_valid", 64'(out_valid), 64'd1);
    tick();
    chk("deliver_b_data", 64'(out_data), 64'h00BB);
    chk("deliver_b_ctrl", 64'(out_ctrl), 64'h6);
    chk("deliver_b_occ", 64'(occupancy), 64'd1);
    chk("deliver_b_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("bp_empty_valid", 64'(out_valid), 64'd0);
    chk("bp_empty_ctrl", 64'(out_ctrl), 64'd0);
    chk("bp_empty_occ", 64'(occupancy), 64'd0);

    // Flush while FULL with a beat offered
    out_ready = 1'b0;
    offer(3'b001, 16'h0011); tick();
    offer(3'b010, 16'h0022); tick();
    chk("fl_full_occ", 64'(occupancy), 64'd2);
    chk("fl_full_stall", 64'(stall_count), 64'd2);
    flush = 1'b1;
    offer(3'b111, 16'h0033);
    tick();
    chk("fl_occ", 64'(occupancy), 64'd0);
    chk("fl_ctrl", 64'(out_ctrl), 64'd0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_stall", 64'(stall_count), 64'd2);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("fl_no_beat", 64'(occupancy), 64'd0);

    // Flush in ONE while in_ready is high: offered beat is still dropped
    offer(3'b001, 16'h0044); tick();
    in_valid = 1'b0;
    chk("fl1_occ_before", 64'(occupancy), 64'd1);
    flush = 1'b1;
    offer(3'b101, 16'h0055);
    #1;
    chk("fl1_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("fl1_occ", 64'(occupancy), 64'd0);
    chk("fl1_ctrl", 64'(out_ctrl), 64'd0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("fl1_no_beat", 64'(occupancy), 64'd0);
    chk("fl1_stall", 64'(stall_count), 64'd2);

    // Flush together with freeze while FULL
    offer(3'b011, 16'h0066); tick();
    offer(3'b100, 16'h0077); tick();
    chk("flfz_full_occ", 64'(occupancy), 64'd2);
    chk("flfz_stall_pre", 64'(stall_count), 64'd3);
    freeze = 1'b1; flush = 1'b1;
    offer(3'b111, 16'h0088);
    tick();
    chk("flfz_occ", 64'(occupancy), 64'd0);
    chk("flfz_ctrl", 64'(out_ctrl), 64'd0);
    freeze = 1'b0; flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("flfz_no_beat", 64'(out_valid), 64'd0);
    chk("flfz_stall", 64'(stall_count), 64'd3);

    // Asynchronous reset mid-stream while FULL
    offer(3'b101, 16'h0009); tick();
    offer(3'b010, 16'h000A); tick();
    in_valid = 1'b0;
    chk("ar_full_occ", 64'(occupancy), 64'd2);
    rst = 1'b0;
    #1;
    chk("ar_in_ready", 64'(in_ready), 64'd0);
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_ctrl", 64'(out_ctrl), 64'd0);
    chk("ar_data", 64'(out_data), 64'd0);
    chk("ar_occ", 64'(occupancy), 64'd0);
    chk("ar_stall", 64'(stall_count), 64'd0);
    @(negedge clk); rst = 1'b1;
    tick();
    chk("ar_post_in_ready", 64'(in_ready), 64'd1);
    chk("ar_post_occ", 64'(occupancy), 64'd0);
    chk("ar_post_stall", 64'(stall_count), 64'd0);

    // Counter saturation at 2 bits
    offer(3'b001, 16'h005A); tick();
    in_valid = 1'b0;
    chk("sat_start", 64'(stall_count), 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("sat_count", 64'(stall_count), 64'(sat_exp[i]));
    end
    chk("sat_data_held", 64'(out_data), 64'h005A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buffer.md
# pipe_stage_buffer

Parametrised pipeline stage register with a valid/ready handshake. It generalises the fixed EXE→MEM style latch to any payload width. Payload is split into a control field, forced to zero whenever the stage holds a bubble, and a data field. A 2-entry skid buffer lets `in_ready` come from a register, so back-pressure never forms a combinational path across the stage. The block also supports freeze, flush and a saturating stall counter. It sits between any two pipeline stages, e.g. EXE→MEM or MEM→WB.

## Interface
- `CTRL_W`, default 3: control bits (e.g. WB_en, MEM_R_EN, MEM_W_EN); zeroed on bubble or flush.
- `DATA_W`, default 132: data bits (e.g. ALU result, store value, PC, instruction, dest).
- `CNT_W`, default 16: stall counter width.
- `clk`  in  1: clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-low reset (asserted when 0).
- `freeze`  in  1: hold all state; masks both handshakes.
- `flush`  in  1: synchronous kill of all held beats; priority over everything except reset.
- `in_valid`  in  1: upstream beat present.
- `in_ready`  out  1: stage can accept.
- `in_ctrl`  in  CTRL_W: upstream control field.
- `in_data`  in  DATA_W: upstream data field.
- `out_valid`  out  1: beat presented downstream.
- `out_ready`  in  1: downstream accepts.
- `out_ctrl`  out  CTRL_W: main-entry control field.
- `out_data`  out  DATA_W: main-entry data field.
- `occupancy`  out  2: number of held beats, 0..2.
- `stall_count`  out  CNT_W: saturating count of back-pressured cycles.

## Operation
- **Storage.** Two entries: main, which drives the outputs, and skid. Each entry has a valid bit, a ctrl register and a data register.
- **Transfers.**
  - Accept = `in_valid & in_ready`.
  - Release = `out_valid & out_ready`.
  - `in_ready = rst & ~skid_valid & ~freeze`.
  - `out_valid = main_valid & ~freeze`.
- **States.** EMPTY (occupancy 0), ONE (main only), FULL (main and skid).
  - EMPTY + accept → ONE, with the beat loaded into main.
  - ONE + accept + release → ONE, with main replaced by the new beat.
  - ONE + accept only → FULL, with the beat loaded into skid.
  - ONE + release only → EMPTY.
  - FULL: no accept is possible. Release → ONE, with skid moved into main and skid cleared.
  - Skid is never valid while main is invalid.
- **Bubble rule.** Whenever main becomes invalid, `main_ctrl` is written to 0; likewise `skid_ctrl` when skid empties. Data registers keep their old value and are don't-care. As a result, `out_ctrl` is 0 whenever occupancy is 0 (outside freeze masking).
- **Freeze.** No register changes, including the counter. `out_ctrl` and `out_data` hold their values. `in_ready` and `out_valid` both read 0.
- **Flush.** Next edge: both valids go to 0, both ctrl fields go to 0, state becomes EMPTY.
  - A beat offered in the flush cycle is discarded, even if `in_ready` = 1.
  - A release in the same cycle still counts downstream. Downstream must qualify with its own flush.
  - Flush wins over freeze.
- **Stall counter.** Increments when `main_valid & ~out_ready & ~freeze & ~flush`. It saturates at 2^CNT_W−1 and is cleared only by reset.

## Timing
- **Reset** (`rst` = 0, asynchronous), immediately and for its duration:
  - all valids 0, all ctrl and data registers 0, `stall_count` 0, `occupancy` 0;
  - `in_ready` 0, `out_valid` 0, `out_ctrl` 0, `out_data` 0.
  - On the first edge after `rst` returns to 1 the state is EMPTY, and `in_ready` = 1 if `freeze` = 0.
- Reset in mid-operation discards held beats with no partial update.
- **Latency:** a beat accepted at edge N appears on `out_*` after edge N, i.e. one cycle.
- **Throughput:** 1 beat/cycle while `out_ready` = 1.
- **Back-pressure:** `in_ready` falls the cycle after the stage becomes FULL. That is one beat of slack, absorbed by skid.
- **Ordering:** strictly FIFO. The skid beat always follows the main beat.
- **Outputs:**
  - `out_ctrl`, `out_data` and `occupancy` are pure register outputs.
  - `in_ready` and `out_valid` are registers ANDed only with `freeze` and `rst`.
  - There is no path from `out_ready` to `in_ready` or from `in_valid` to `out_valid`.

## Test plan
- **Reset:** drive `rst` = 0 mid-stream with occupancy 2 → all outputs 0 immediately. After release: `in_ready` = 1, `occupancy` = 0, `stall_count` = 0.
- **Streaming:** `out_ready` = 1, send data 0x1..0x8 with ctrl 3'b101 on 8 consecutive cycles → same sequence out, each one cycle later. `occupancy` stays 1, `stall_count` stays 0.
- **Back-pressure:** `out_ready` = 0, send A and B on consecutive cycles → `occupancy` = 2, `in_ready` = 0, `out_data` = A. Raise `out_ready` → A then B delivered, then `out_valid` = 0 and `out_ctrl` = 0.
- **Freeze:** freeze for 3 cycles while FULL → `in_ready` = 0, `out_valid` = 0, outputs and `stall_count` unchanged. Unfreeze → delivery resumes in order.
- **Flush:** flush while FULL with a beat offered in the same cycle, and again with `freeze` also high → next cycle `occupancy` = 0, `out_ctrl` = 0, offered beat never appears.
- **Counter saturation:** `CNT_W` = 2, hold `out_ready` = 0 for 6 cycles with main valid → `stall_count` reads 1, 2, 3, 3, 3, 3.
